// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, drives datapath selects and strobes.
// Optional feature macro ILLEGAL_TRAP_EN: illegal instructions halt and set a sticky flag; otherwise they retire as NOPs.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt_field,
  input  logic       zero,
  input  logic       pc_is_zero,
  input  logic       mem_waitrequest,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       active,
  output logic       illegal
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_HALT
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110, ALU_SLT  = 4'b0111, ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101, ALU_BNE  = 4'b1000, ALU_BGTZ = 4'b1001;
  localparam logic [3:0] ALU_BLEZ = 4'b1010, ALU_BGEZ = 4'b1011, ALU_BLTZ = 4'b1111;

  state_t     state_q, state_d, dispatch;
  logic       reg_dst_q, reg_dst_d;
  logic [3:0] r_alu, i_alu, br_alu;
  logic       r_ok, bad_instr;

  // Instruction decode tables, evaluated every cycle from the stable IR fields.
  always_comb begin
    r_ok = 1'b1;
    r_alu = ALU_ADD;
    casez (funct)
      6'b10000?: r_alu = ALU_ADD;
      6'b10001?: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_ok = 1'b0;
    endcase
    i_alu = ALU_ADD;
    case (opcode)
      6'b001010: i_alu = ALU_SLT;
      6'b001100: i_alu = ALU_AND;
      6'b001101: i_alu = ALU_OR;
      6'b001110: i_alu = ALU_XOR;
      default:   i_alu = ALU_ADD;
    endcase
    br_alu = ALU_SUB;
    case (opcode)
      6'b000101: br_alu = ALU_BNE;
      6'b000110: br_alu = ALU_BLEZ;
      6'b000111: br_alu = ALU_BGTZ;
      6'b000001: br_alu = rt_field[0] ? ALU_BGEZ : ALU_BLTZ;
      default:   br_alu = ALU_SUB;
    endcase
    bad_instr = 1'b0;
    dispatch = S_FETCH;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b001000) dispatch = S_JR;
        else if (r_ok)          dispatch = S_EXEC_R;
        else                    bad_instr = 1'b1;
      end
      6'b100011, 6'b101011:                         dispatch = S_MEM_ADDR;
      6'b000100, 6'b000101, 6'b000110, 6'b000111:   dispatch = S_BRANCH;
      6'b000001: begin
        if (rt_field[4:1] == 4'd0) dispatch = S_BRANCH;
        else                       bad_instr = 1'b1;
      end
      6'b000010:                                    dispatch = S_JUMP;
      6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110: dispatch = S_EXEC_I;
      default:                                      bad_instr = 1'b1;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q & ~reset;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      reg_dst_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      reg_dst_q <= reg_dst_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    reg_dst_d   = reg_dst_q;
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    active      = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    // Reset masks every strobe so an aborted instruction never half-commits.
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (pc_is_zero) begin
            state_d = S_HALT;
          end else begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (!mem_waitrequest) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          if (bad_instr) begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end else begin
            state_d = dispatch;
          end
        end
        S_EXEC_R: begin
          alu_src_a   = 1'b1;
          alu_control = r_alu;
          reg_dst_d   = 1'b1;
          state_d     = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = i_alu;
          reg_dst_d   = 1'b0;
          state_d     = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = reg_dst_q;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = opcode[3] ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (!mem_waitrequest) state_d = S_MEM_WB;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (!mem_waitrequest) state_d = S_FETCH;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = br_alu;
          pc_write    = zero;
          pc_src      = 2'b01;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_FETCH;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          state_d  = S_FETCH;
        end
        S_HALT:  active = 1'b0;
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed cases then random instruction stream
// against a per-instruction expected-cycle list built from the instruction classes.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset, zero, pc_is_zero, mem_waitrequest;
  logic [5:0] opcode, funct;
  logic [4:0] rt_field;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       active, illegal;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rt_field(rt_field),
    .zero(zero), .pc_is_zero(pc_is_zero), .mem_waitrequest(mem_waitrequest),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .active(active), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, active, illegal;
    logic       iord, reg_dst, mem_to_reg, src_a;
    logic [1:0] src_b, pc_src;
    logic [3:0] alu;
  } ov_t;
  typedef struct packed { ov_t hold; ov_t rel; ov_t mask; logic mem; } step_t;
  typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JR, K_ILL} kind_t;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  ov_t obs;
  assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, active, illegal,
                iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control};

  logic [5:0] r_funcs [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                               6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b001000};
  logic [5:0] i_ops [5] = '{6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110};

  function automatic ov_t base_exp();
    ov_t e = '0;
    e.active = 1'b1;
    e.alu = 4'b0010;
    return e;
  endfunction

  function automatic ov_t m_base();
    ov_t m = '0;
    {m.pc_write, m.ir_write, m.mem_read, m.mem_write, m.reg_write, m.active, m.illegal} = 7'h7F;
    return m;
  endfunction

  function automatic ov_t m_sel();
    ov_t m = m_base();
    m.src_a = 1'b1;
    m.src_b = 2'b11;
    m.alu = 4'hF;
    return m;
  endfunction

  // Instruction class and ALU code straight from the ISA tables.
  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt, output logic [3:0] alu);
    kind_t k = K_ILL;
    alu = 4'b0010;
    if (op == 6'b000000) begin
      if (fn == 6'b001000) k = K_JR;
      else if (fn inside {6'b100000, 6'b100001}) begin k = K_R; alu = 4'b0010; end
      else if (fn inside {6'b100010, 6'b100011}) begin k = K_R; alu = 4'b0110; end
      else if (fn == 6'b100100) begin k = K_R; alu = 4'b0000; end
      else if (fn == 6'b100101) begin k = K_R; alu = 4'b0001; end
      else if (fn == 6'b100110) begin k = K_R; alu = 4'b1101; end
      else if (fn == 6'b100111) begin k = K_R; alu = 4'b1100; end
      else if (fn == 6'b101010) begin k = K_R; alu = 4'b0111; end
    end
    else if (op == 6'b001001) begin k = K_I; alu = 4'b0010; end
    else if (op == 6'b001010) begin k = K_I; alu = 4'b0111; end
    else if (op == 6'b001100) begin k = K_I; alu = 4'b0000; end
    else if (op == 6'b001101) begin k = K_I; alu = 4'b0001; end
    else if (op == 6'b001110) begin k = K_I; alu = 4'b1101; end
    else if (op == 6'b100011) k = K_LW;
    else if (op == 6'b101011) k = K_SW;
    else if (op == 6'b000100) begin k = K_BR; alu = 4'b0110; end
    else if (op == 6'b000101) begin k = K_BR; alu = 4'b1000; end
    else if (op == 6'b000110) begin k = K_BR; alu = 4'b1010; end
    else if (op == 6'b000111) begin k = K_BR; alu = 4'b1001; end
    else if (op == 6'b000001 && rt == 5'd0) begin k = K_BR; alu = 4'b1111; end
    else if (op == 6'b000001 && rt == 5'd1) begin k = K_BR; alu = 4'b1011; end
    else if (op == 6'b000010) k = K_J;
    return k;
  endfunction

  task automatic chk(input string tag, input ov_t exp, input ov_t m);
    logic [18:0] ov, ev, mv;
    ov = obs; ev = exp; mv = m;
    checks++;
    assert ((ov & mv) === (ev & mv)) else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h (mask %05h)", tag, ov & mv, ev & mv, mv);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick(input logic rst, input logic w, input logic z, input logic pcz,
                      input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    @(negedge clk);
    reset = rst; mem_waitrequest = w; zero = z; pc_is_zero = pcz;
    opcode = op; funct = fn; rt_field = rt;
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), 5'($urandom));
      chk("reset_outputs", base_exp(), '1);
    end
  endtask

  task automatic halt_check(input int n, input logic ill);
    ov_t e;
    e = base_exp();
    e.active = 1'b0;
    e.illegal = ill;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), 5'($urandom));
      chk("halt_state", e, m_base());
    end
  endtask

  // fw/mw: wait cycles on fetch / data access (-1 = random 0..2); abort asserts reset in the data-access stall.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rt, input logic z, input int fw, input int mw,
                           input bit abort, output int cyc, output bit halted);
    step_t q[$];
    step_t s;
    kind_t k;
    logic [3:0] alu;
    int nw;
    k = classify(op, fn, rt, alu);
    cyc = 0;
    halted = (k == K_ILL) && TRAP;
    s.mem = 1'b1;
    s.hold = base_exp(); s.hold.mem_read = 1'b1; s.hold.src_b = 2'b01;
    s.mask = m_sel(); s.mask.iord = 1'b1; s.mask.pc_src = 2'b11;
    s.rel = s.hold; s.rel.ir_write = 1'b1; s.rel.pc_write = 1'b1;
    q.push_back(s);
    s.mem = 1'b0;
    s.rel = base_exp(); s.rel.src_b = 2'b11; s.mask = m_sel();
    q.push_back(s);
    s.rel = base_exp(); s.mask = m_sel();
    case (k)
      K_R, K_I: begin
        s.rel.src_a = 1'b1; s.rel.alu = alu; s.rel.src_b = (k == K_I) ? 2'b10 : 2'b00;
        q.push_back(s);
        s.rel = base_exp(); s.rel.reg_write = 1'b1; s.rel.reg_dst = (k == K_R);
        s.mask = m_base(); s.mask.reg_dst = 1'b1; s.mask.mem_to_reg = 1'b1;
        q.push_back(s);
      end
      K_LW, K_SW: begin
        s.rel.src_a = 1'b1; s.rel.src_b = 2'b10;
        q.push_back(s);
        s.mem = 1'b1;
        s.rel = base_exp(); s.rel.iord = 1'b1; s.mask = m_base(); s.mask.iord = 1'b1;
        if (k == K_LW) s.rel.mem_read = 1'b1; else s.rel.mem_write = 1'b1;
        s.hold = s.rel;
        q.push_back(s);
        if (k == K_LW) begin
          s.mem = 1'b0;
          s.rel = base_exp(); s.rel.reg_write = 1'b1; s.rel.mem_to_reg = 1'b1;
          s.mask = m_base(); s.mask.reg_dst = 1'b1; s.mask.mem_to_reg = 1'b1;
          q.push_back(s);
        end
      end
      K_BR: begin
        s.rel.src_a = 1'b1; s.rel.alu = alu; s.rel.pc_write = z; s.rel.pc_src = 2'b01;
        s.mask.pc_src = 2'b11;
        q.push_back(s);
      end
      K_J, K_JR: begin
        s.rel.pc_write = 1'b1; s.rel.pc_src = (k == K_J) ? 2'b10 : 2'b11;
        s.mask = m_base(); s.mask.pc_src = 2'b11;
        q.push_back(s);
      end
      default: ;
    endcase
    foreach (q[i]) begin
      if (q[i].mem) begin
        nw = (i == 0) ? fw : mw;
        if (nw < 0) nw = $urandom_range(0, 2);
        for (int w = 0; w < nw; w++) begin
          if (abort && i > 0) begin
            tick(1'b1, 1'b1, 1'($urandom), 1'b0, op, fn, rt);
            chk({tag, "_reset_abort"}, base_exp(), '1);
            cyc++;
            return;
          end
          tick(1'b0, 1'b1, 1'($urandom), 1'b0, op, fn, rt);
          chk({tag, "_stall"}, q[i].hold, q[i].mask);
          cyc++;
        end
        tick(1'b0, 1'b0, 1'($urandom), 1'b0, op, fn, rt);
      end else begin
        tick(1'b0, 1'($urandom), (k == K_BR && i == 2) ? z : 1'($urandom), 1'b0, op, fn, rt);
      end
      chk(tag, q[i].rel, q[i].mask);
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    bit  h;
    ov_t e;
    reset = 1'b1; zero = 1'b0; pc_is_zero = 1'b0; mem_waitrequest = 1'b0;
    opcode = '0; funct = '0; rt_field = '0;
    do_reset(2);

    run_instr("addu", 6'b000000, 6'b100001, 5'd3, 1'b0, 0, 0, 1'b0, cyc, h);
    chk_int("addu_cycles", cyc, 4);
    run_instr("lw_wait2", 6'b100011, 6'b010101, 5'd2, 1'b0, 0, 2, 1'b0, cyc, h);
    chk_int("lw_wait2_cycles", cyc, 7);
    run_instr("sw", 6'b101011, 6'b000000, 5'd4, 1'b0, 0, 0, 1'b0, cyc, h);
    chk_int("sw_cycles", cyc, 4);
    run_instr("bne_taken", 6'b000101, 6'b000000, 5'd1, 1'b1, 0, 0, 1'b0, cyc, h);
    chk_int("branch_cycles", cyc, 3);
    run_instr("bne_not_taken", 6'b000101, 6'b000000, 5'd1, 1'b0, 0, 0, 1'b0, cyc, h);
    run_instr("bltz", 6'b000001, 6'b000000, 5'd0, 1'b1, 0, 0, 1'b0, cyc, h);
    run_instr("bgez", 6'b000001, 6'b000000, 5'd1, 1'b1, 1, 0, 1'b0, cyc, h);
    run_instr("slti", 6'b001010, 6'b111111, 5'd7, 1'b0, 0, 0, 1'b0, cyc, h);
    run_instr("j", 6'b000010, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, cyc, h);
    chk_int("jump_cycles", cyc, 3);
    run_instr("sw_abort", 6'b101011, 6'b000000, 5'd4, 1'b0, 0, 3, 1'b1, cyc, h);
    run_instr("after_abort", 6'b000000, 6'b100100, 5'd5, 1'b0, 0, 0, 1'b0, cyc, h);
    run_instr("illegal_op", 6'b111111, 6'b000000, 5'd0, 1'b0, 0, 0, 1'b0, cyc, h);
    chk_int("illegal_cycles", cyc, 2);
    if (h) begin
      halt_check(3, 1'b1);
      do_reset(1);
    end
    run_instr("jr", 6'b000000, 6'b001000, 5'd0, 1'b0, 0, 0, 1'b0, cyc, h);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 6'b100011, 6'b000000, 5'd0);
    e = base_exp();
    chk("fetch_at_pc0", e, m_base());
    halt_check(5, 1'b0);
    do_reset(1);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      logic [4:0] rt;
      op = 6'($urandom); fn = 6'($urandom); rt = 5'($urandom);
      case ($urandom_range(0, 9))
        0: begin op = 6'b000000; fn = r_funcs[$urandom_range(0, 9)]; end
        1: op = 6'b000000;
        2: op = i_ops[$urandom_range(0, 4)];
        3: op = 6'b100011;
        4: op = 6'b101011;
        5: op = 6'($urandom_range(4, 7));
        6: begin op = 6'b000001; rt = 5'($urandom_range(0, 3)); end
        7: op = 6'b000010;
        8: begin op = 6'b000000; fn = 6'b001000; end
        default: ;
      endcase
      run_instr("rand", op, fn, rt, 1'($urandom), -1, -1, 1'b0, cyc, h);
      if (h) begin
        halt_check(2, 1'b1);
        do_reset(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
